// File: rtl/cut_ctl_agc_pkg.sv
// Shared constants and helpers for the per-frame cut selector and the
// 32-to-16-bit truncation stage it drives.
package cut_ctl_agc_pkg;

  localparam logic [2:0] CUT_SAFE   = 3'd7;
  localparam int         GAIN_MAX   = 7;
  localparam int         HDRM_W_MAX = 64;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } agc_state_t;

  // Level 0 is the coarsest cut; level k+1 selects cut code k.
  function automatic logic [2:0] level_to_cut(input logic [2:0] lvl);
    return (lvl == 3'd0) ? CUT_SAFE : lvl - 3'd1;
  endfunction

  function automatic logic [2:0] cut_to_level(input logic [2:0] cut);
    return (cut == CUT_SAFE) ? 3'd0 : cut + 3'd1;
  endfunction

  // Redundant sign bits below the MSB of a len-bit word, capped at GAIN_MAX.
  function automatic logic [2:0] hdrm_count(input logic [HDRM_W_MAX-1:0] word,
                                            input int unsigned           len);
    logic [2:0] cnt;
    logic       run;
    logic       sign;
    logic [5:0] idx;
    cnt  = '0;
    run  = 1'b1;
    sign = word[6'(len - 1)];
    for (int i = 1; i <= GAIN_MAX; i++) begin
      idx = 6'(len - 1 - i);
      if (run && (word[idx] == sign)) cnt = cnt + 3'd1;
      else                            run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cut_hdrm_det.sv
// Combinational sign-headroom count of one LEN-bit two's-complement word.
module cut_hdrm_det
  import cut_ctl_agc_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] word_i,
  output logic [2:0]     hdrm_o
);

  assign hdrm_o = hdrm_count(HDRM_W_MAX'(word_i), LEN);

endmodule

// File: rtl/cut_ctl_agc.sv
// Per-frame automatic cut selector: tracks worst-case I/Q headroom over a
// frame and picks the finest safe cut, fast attack / slow release.
module cut_ctl_agc
  import cut_ctl_agc_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int HOLD_FRAMES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN-1:0]   data_i,
  input  logic [LEN-1:0]   data_q,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic             man_en,
  input  logic [2:0]       man_cut,
  output logic [2:0]       cut_ctl,
  output logic             cut_upd,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [2:0]       hr_min
);

  localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [2:0] r_i, r_q, r_s;

  cut_hdrm_det #(.LEN(LEN)) u_det_i (.word_i(data_i), .hdrm_o(r_i));
  cut_hdrm_det #(.LEN(LEN)) u_det_q (.word_i(data_q), .hdrm_o(r_q));

  assign r_s = (r_i < r_q) ? r_i : r_q;

  agc_state_t        state_q;
  logic              s1_vld_q, s1_sat_q, s1_fs_q, s1_dec_q;
  logic [2:0]        s1_r_q;
  logic [2:0]        acc_min_q, acc_min_d;
  logic [CNT_W-1:0]  acc_sat_q, acc_sat_d;
  logic              acc_n_q, acc_n_d;
  logic [2:0]        frm_min_q;
  logic [CNT_W-1:0]  frm_sat_q;
  logic              frm_n_q, dec_q;
  logic [2:0]        g_q, g_d, cut_q, cut_d, hr_min_q, hr_min_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;
  logic              upd_q, upd_d;

  // A frame boundary reloads the accumulator, then folds in the sample in flight.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    acc_min_d = s1_fs_q ? 3'd7 : acc_min_q;
    acc_sat_d = s1_fs_q ? '0   : acc_sat_q;
    acc_n_d   = s1_fs_q ? 1'b0 : acc_n_q;
    if (s1_vld_q) begin
      if (s1_r_q < acc_min_d) acc_min_d = s1_r_q;
      if (acc_sat_d != '1)    acc_sat_d = acc_sat_d + {{(CNT_W-1){1'b0}}, s1_sat_q};
      acc_n_d = 1'b1;
    end
  end

  always_comb begin
    g_d       = g_q;
    hold_d    = hold_q;
    cut_d     = cut_q;
    hr_min_d  = hr_min_q;
    sat_cnt_d = sat_cnt_q;
    upd_d     = 1'b0;
    if (dec_q && frm_n_q) begin
      upd_d     = 1'b1;
      hr_min_d  = frm_min_q;
      sat_cnt_d = frm_sat_q;
      if (man_en) begin
        cut_d  = man_cut;
        g_d    = cut_to_level(man_cut);
        hold_d = '0;
      end else begin
        if (frm_min_q < g_q) begin
          g_d    = frm_min_q;
          hold_d = '0;
        end else if (frm_min_q > g_q) begin
          if (hold_q == HOLD_LAST) begin
            g_d    = g_q + 3'd1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
        cut_d = level_to_cut(g_d);
      end
    end
  end

  // Samples are only admitted once the first frame boundary has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      state_q   <= ST_IDLE;
      s1_vld_q  <= 1'b0;
      s1_sat_q  <= 1'b0;
      s1_fs_q   <= 1'b0;
      s1_dec_q  <= 1'b0;
      s1_r_q    <= 3'd7;
      acc_min_q <= 3'd7;
      acc_sat_q <= '0;
      acc_n_q   <= 1'b0;
      frm_min_q <= 3'd7;
      frm_sat_q <= '0;
      frm_n_q   <= 1'b0;
      dec_q     <= 1'b0;
      g_q       <= 3'd0;
      hold_q    <= '0;
      cut_q     <= CUT_SAFE;
      hr_min_q  <= 3'd7;
      sat_cnt_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && frame_start) state_q <= ST_ACCUM;
      s1_vld_q  <= in_valid && (state_q == ST_ACCUM || frame_start);
      s1_r_q    <= r_s;
      s1_sat_q  <= (r_s < g_q);
      s1_fs_q   <= frame_start;
      s1_dec_q  <= frame_start && (state_q == ST_ACCUM);
      acc_min_q <= acc_min_d;
      acc_sat_q <= acc_sat_d;
      acc_n_q   <= acc_n_d;
      if (s1_fs_q) begin
        frm_min_q <= acc_min_q;
        frm_sat_q <= acc_sat_q;
        frm_n_q   <= acc_n_q;
      end
      dec_q     <= s1_dec_q;
      g_q       <= g_d;
      hold_q    <= hold_d;
      cut_q     <= cut_d;
      hr_min_q  <= hr_min_d;
      sat_cnt_q <= sat_cnt_d;
      upd_q     <= upd_d;
    end
  end

  assign cut_ctl = cut_q;
  assign cut_upd = upd_q;
  assign sat_cnt = sat_cnt_q;
  assign hr_min  = hr_min_q;

endmodule
